// File: rtl/lift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lift_pkg
//  Description : Shared definitions for the hall-call front end: call codes,
//                motor command values, encoder state enum and the
//                button-index to call-code mapping.
//  Revision    : 1.0  initial release
// ============================================================================
package lift_pkg;

    // Call codes presented to the lift controller
    localparam logic [2:0] CALL_NONE = 3'b000;
    localparam logic [2:0] CALL_1U   = 3'b001;
    localparam logic [2:0] CALL_2U   = 3'b010;
    localparam logic [2:0] CALL_3U   = 3'b011;
    localparam logic [2:0] CALL_2D   = 3'b110;
    localparam logic [2:0] CALL_3D   = 3'b111;
    localparam logic [2:0] CALL_4D   = 3'b100;

    // Motor command from the lift controller
    localparam logic [1:0] UP   = 2'b00;
    localparam logic [1:0] DOWN = 2'b01;
    localparam logic [1:0] STAY = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DWELL = 3'd3,
        FAULT = 3'd4
    } enc_state_t;

    // Button index: 0=1U, 1=2U, 2=3U, 3=2D, 4=3D, 5=4D
    function automatic logic [2:0] call_code(input logic [2:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = CALL_1U;
            3'd1:    code = CALL_2U;
            3'd2:    code = CALL_3U;
            3'd3:    code = CALL_2D;
            3'd4:    code = CALL_3D;
            3'd5:    code = CALL_4D;
            default: code = CALL_NONE;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lift_call_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : lift_call_rr_arb
//  Description : 6-bit round-robin arbiter. The search starts at the bit
//                after the last granted one; the pointer moves only when
//                the advance strobe is high with a valid grant.
//  Ports       : clk, rst_n      clock, async active-low reset
//                req_vec[5:0]    request vector
//                adv             advance strobe (grant is being consumed)
//                grant_idx[2:0]  index of the granted request
//                grant_vld       some request is granted
//  Revision    : 1.0  initial release
// ============================================================================
module lift_call_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] req_vec,
    input  logic       adv,
    output logic [2:0] grant_idx,
    output logic       grant_vld
);

    logic [2:0] ptr_q, ptr_d;
    logic [3:0] w_pos;

    always_comb begin
        grant_idx = 3'd0;
        grant_vld = 1'b0;
        w_pos     = 4'd0;
        for (int i = 0; i < 6; i++) begin
            // Position modulo 6, starting from the pointer
            w_pos = {1'b0, ptr_q} + 4'(i);
            if (w_pos >= 4'd6) begin
                w_pos = w_pos - 4'd6;
            end
            if (!grant_vld && req_vec[w_pos[2:0]]) begin
                grant_vld = 1'b1;
                grant_idx = w_pos[2:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv && grant_vld) begin
            ptr_d = (grant_idx == 3'd5) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lift_call_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : lift_call_encoder
//  Description : Hall-call front end. Edge-detects six hall buttons into a
//                pending register (drives lamps), issues one pending call at
//                a time in round-robin order, then waits for the lift to
//                settle and a door dwell before the next issue. A WAIT that
//                exceeds TIMEOUT_CYCLES latches a fault until reset.
//  Macro       : LIFT_CALL_SYNC_EN - adds a 2-flop synchronizer on btn.
//  Ports       : clk, rst_n      clock, async active-low reset
//                btn[5:0]        raw hall buttons (1U,2U,3U,2D,3D,4D)
//                lift_out[1:0]   motor command (UP/DOWN/STAY)
//                req[2:0]        registered call code, non-NONE only in ISSUE
//                lamp[5:0]       pending-call lamps
//                busy            high in ISSUE, WAIT, DWELL
//                fault           sticky timeout flag
//  Revision    : 1.0  initial release
// ============================================================================
module lift_call_encoder
    import lift_pkg::*;
#(
    parameter int DWELL_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] btn,
    input  logic [1:0] lift_out,
    output logic [2:0] req,
    output logic [5:0] lamp,
    output logic       busy,
    output logic       fault
);

    localparam int CNT_TOP = (DWELL_CYCLES > TIMEOUT_CYCLES) ? DWELL_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    localparam logic [CNT_W-1:0] C_CNT_SAT      = CNT_W'(CNT_TOP);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_DWELL_LAST   = CNT_W'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);

    enc_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       pend_q, pend_d;
    logic [5:0]       btn_prev_q;
    logic [2:0]       grant_q, grant_d;
    logic [2:0]       req_q, req_d;

    logic [5:0]       w_btn_s;
    logic [5:0]       w_edge;
    logic [2:0]       w_grant_idx;
    logic             w_grant_vld;
    logic             w_issue_start;

`ifdef LIFT_CALL_SYNC_EN
    logic [5:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 6'd0;
            sync2_q <= 6'd0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    assign w_btn_s = sync2_q;
`else
    assign w_btn_s = btn;
`endif

    assign w_edge = w_btn_s & ~btn_prev_q;

    lift_call_rr_arb u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_vec   (pend_q),
        .adv       (w_issue_start),
        .grant_idx (w_grant_idx),
        .grant_vld (w_grant_vld)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        req_d         = CALL_NONE;
        w_issue_start = 1'b0;
        pend_d        = pend_q | w_edge;

        case (state_q)
            IDLE: begin
                if (w_grant_vld && lift_out == STAY) begin
                    state_d       = ISSUE;
                    grant_d       = w_grant_idx;
                    req_d         = call_code(w_grant_idx);
                    w_issue_start = 1'b1;
                end
            end
            ISSUE: begin
                // Clear overrides a same-cycle press of the granted button
                pend_d[grant_q] = 1'b0;
                state_d         = WAIT;
            end
            WAIT: begin
                // The settle decision is made inside WAIT, so at least one
                // WAIT cycle always elapses before leaving.
                if (lift_out == STAY) begin
                    state_d = (DWELL_CYCLES == 0) ? IDLE : DWELL;
                end else if (cnt_q == C_TIMEOUT_LAST) begin
                    state_d = FAULT;
                end
            end
            DWELL: begin
                if (cnt_q == C_DWELL_LAST) begin
                    state_d = IDLE;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Shared WAIT/DWELL counter: clears on any state change, saturates
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == WAIT || state_q == DWELL) && cnt_q != C_CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_q     <= 6'd0;
            btn_prev_q <= 6'd0;
            grant_q    <= 3'd0;
            req_q      <= CALL_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            btn_prev_q <= w_btn_s;
            grant_q    <= grant_d;
            req_q      <= req_d;
        end
    end

    assign req   = req_q;
    assign lamp  = pend_q;
    assign busy  = (state_q == ISSUE) || (state_q == WAIT) || (state_q == DWELL);
    assign fault = (state_q == FAULT);

endmodule
`default_nettype wire

// File: tb/tb_lift_call_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lift_call_encoder
//  Description : Self-checking bench for lift_call_encoder (DWELL_CYCLES=4,
//                TIMEOUT_CYCLES=16). Directed scenarios plus a randomized
//                run against a timestamp-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lift_call_encoder;

    localparam int DWELL   = 4;
    localparam int TIMEOUT = 16;
`ifdef LIFT_CALL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam logic [1:0] M_UP   = 2'b00;
    localparam logic [1:0] M_DOWN = 2'b01;
    localparam logic [1:0] M_STAY = 2'b10;
    localparam int BIG = 32'h7fff_ffff;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] btn = 6'd0;
    logic [1:0] lift_out = M_STAY;
    logic [2:0] req;
    logic [5:0] lamp;
    logic       busy;
    logic       fault;

    int n_tests = 0;
    int n_fail  = 0;

    lift_call_encoder #(
        .DWELL_CYCLES   (DWELL),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .lift_out (lift_out),
        .req      (req),
        .lamp     (lamp),
        .busy     (busy),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] code_of(input int idx);
        case (idx)
            0: return 3'b001;
            1: return 3'b010;
            2: return 3'b011;
            3: return 3'b110;
            4: return 3'b111;
            5: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        btn      = 6'd0;
        lift_out = M_STAY;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Reset asserted mid-WAIT must clear outputs without a clock edge
    task automatic test_reset();
        do_reset();
        for (int c = 0; c <= 4 + LAT; c++) begin
            btn      = (c == 0) ? 6'b010001 : 6'd0;
            lift_out = (c >= 2 + LAT) ? M_UP : M_STAY;
            if (c == 4 + LAT) begin
                n_tests++;
                if (busy !== 1'b1 || lamp !== 6'b010000) begin
                    n_fail++;
                    $display("FAIL reset_pre: busy=%b lamp=%b expected busy=1 lamp=010000", busy, lamp);
                end
            end
            if (c < 4 + LAT) tick();
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (req !== 3'b000 || lamp !== 6'd0 || busy !== 1'b0 || fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: req=%b lamp=%b busy=%b fault=%b expected all zero", req, lamp, busy, fault);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        lift_out = M_STAY;
        btn      = 6'd0;
        tick();
        for (int c = 0; c < 6; c++) begin
            n_tests++;
            if (req !== 3'b000 || lamp !== 6'd0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d: req=%b lamp=%b busy=%b expected 000/0/0", c, req, lamp, busy);
            end
            tick();
        end
        for (int c = 0; c <= 2 + LAT; c++) begin
            btn = (c == 0) ? 6'b000010 : 6'd0;
            if (c == 2 + LAT) begin
                n_tests++;
                if (req !== 3'b010) begin
                    n_fail++;
                    $display("FAIL reset_after_issue: req=%b expected 010", req);
                end
            end
            tick();
        end
    endtask

    task automatic test_single_call();
        logic [2:0] exp_req;
        logic       exp_lamp;
        logic       exp_busy;
        do_reset();
        for (int c = 0; c <= 12 + LAT; c++) begin
            btn      = (c == 0) ? 6'b000001 : 6'd0;
            lift_out = (c >= 3 + LAT && c <= 4 + LAT) ? M_UP : M_STAY;
            exp_req  = (c == 2 + LAT) ? 3'b001 : 3'b000;
            exp_lamp = (c >= 1 + LAT && c <= 2 + LAT);
            exp_busy = (c >= 2 + LAT && c <= 9 + LAT);
            n_tests++;
            if (req !== exp_req || lamp[0] !== exp_lamp || busy !== exp_busy || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL single_call c=%0d: req=%b lamp0=%b busy=%b fault=%b expected %b/%b/%b/0",
                         c, req, lamp[0], busy, fault, exp_req, exp_lamp, exp_busy);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] got[$];
        logic [2:0] exp[$];
        logic [5:0] presses[3];
        presses[0] = 6'b101001;
        presses[1] = 6'b000001;
        presses[2] = 6'b001001;
        exp = '{3'b001, 3'b110, 3'b100, 3'b001, 3'b110, 3'b001};
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 40; c++) begin
                btn = (c == 0) ? presses[p] : 6'd0;
                if (req !== 3'b000) got.push_back(req);
                tick();
            end
        end
        n_tests++;
        if (got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL rr_count: got %0d issues expected %0d", got.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                n_tests++;
                if (got[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d]: req=%b expected %b", i, got[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_held_button();
        int issues = 0;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            btn = (c < 50) ? 6'b000010 : 6'd0;
            if (req === 3'b010) issues++;
            tick();
        end
        n_tests++;
        if (issues != 1 || lamp[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL held_button: issues=%0d lamp1=%b expected 1 issue lamp1=0", issues, lamp[1]);
        end
    endtask

    task automatic test_timeout();
        logic exp_fault;
        logic exp_busy;
        do_reset();
        for (int c = 0; c <= 20 + LAT; c++) begin
            btn       = (c == 0) ? 6'b000001 : 6'd0;
            lift_out  = (c >= 2 + LAT) ? M_UP : M_STAY;
            exp_fault = (c >= 19 + LAT);
            exp_busy  = (c >= 2 + LAT && c < 19 + LAT);
            n_tests++;
            if (fault !== exp_fault || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL timeout c=%0d: fault=%b busy=%b expected %b/%b", c, fault, busy, exp_fault, exp_busy);
            end
            tick();
        end
        lift_out = M_STAY;
        for (int c = 0; c < 15; c++) begin
            btn = (c == 0) ? 6'b000100 : 6'd0;
            n_tests++;
            if (req !== 3'b000 || fault !== 1'b1 || busy !== 1'b0 ||
                (c >= 1 + LAT && lamp[2] !== 1'b1)) begin
                n_fail++;
                $display("FAIL fault_hold c=%0d: req=%b fault=%b busy=%b lamp2=%b expected 000/1/0/lamp2=1",
                         c, req, fault, busy, lamp[2]);
            end
            tick();
        end
        do_reset();
        n_tests++;
        if (fault !== 1'b0 || lamp !== 6'd0) begin
            n_fail++;
            $display("FAIL fault_clear: fault=%b lamp=%b expected 0/000000", fault, lamp);
        end
    endtask

    // Randomized run against a model built on event timestamps:
    // the cycle of the next ISSUE and the first cycle the block is idle again.
    task automatic test_random();
        logic [5:0] pipe[$];
        logic [5:0] m_pend = 6'd0;
        logic [5:0] seen = 6'd0;
        logic [5:0] eff, edges, nxt;
        logic [5:0] btn_v = 6'd0;
        logic [1:0] lift_v;
        logic [2:0] exp_req;
        logic [2:0] issue_code = 3'b000;
        logic       exp_busy;
        int m_ptr = 0;
        int issue_at = -1;
        int idle_from = 0;
        int grant_bit = 0;
        int up_run = 0;
        int r, g;
        bit waiting = 1'b0;
        do_reset();
        for (int i = 0; i < LAT; i++) pipe.push_back(6'd0);
        for (int n = 0; n < 800; n++) begin
            exp_req  = (n == issue_at) ? issue_code : 3'b000;
            exp_busy = (issue_at >= 0 && n >= issue_at && n < idle_from);
            n_tests++;
            if (req !== exp_req || lamp !== m_pend || busy !== exp_busy || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL random n=%0d: req=%b lamp=%b busy=%b fault=%b expected %b/%b/%b/0",
                         n, req, lamp, busy, fault, exp_req, m_pend, exp_busy);
            end
            btn_v = btn_v ^ (6'($urandom) & 6'($urandom) & 6'($urandom));
            r = $urandom_range(0, 9);
            if (r < 3 && up_run < 8) begin
                lift_v = (r == 0) ? M_DOWN : M_UP;
                up_run++;
            end else begin
                lift_v = M_STAY;
                up_run = 0;
            end
            btn      = btn_v;
            lift_out = lift_v;

            pipe.push_back(btn_v);
            eff   = pipe.pop_front();
            edges = eff & ~seen;
            seen  = eff;
            nxt   = m_pend | edges;
            if (n == issue_at) nxt[grant_bit] = 1'b0;
            if (n >= idle_from && m_pend != 6'd0 && lift_v == M_STAY) begin
                g = -1;
                for (int k = 0; k < 6; k++) begin
                    if (g < 0 && m_pend[(m_ptr + k) % 6]) g = (m_ptr + k) % 6;
                end
                grant_bit  = g;
                issue_code = code_of(g);
                m_ptr      = (g + 1) % 6;
                issue_at   = n + 1;
                idle_from  = BIG;
                waiting    = 1'b1;
            end else if (waiting && n > issue_at && lift_v == M_STAY) begin
                idle_from = n + 1 + DWELL;
                waiting   = 1'b0;
            end
            m_pend = nxt;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_round_robin();
        test_held_button();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lift_call_encoder.md
# lift_call_encoder

Hall-call front end for the lift controller. It edge-detects the six hall-call buttons, latches them as pending calls, and drives lamps for pending calls. It picks one pending call at a time with a round-robin arbiter and presents it to the lift controller as a 3-bit call code. It watches the controller's 2-bit motor command so that it issues the next call only after the lift has settled and the door dwell has elapsed.

## Interface
Parameters:
- DWELL_CYCLES, 8: idle cycles inserted after the lift settles, before the next issue; 0 means no dwell.
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before a fault is declared; must be at least 1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- btn  in  6  raw hall buttons, level. Bit mapping: [0]=1U, [1]=2U, [2]=3U, [3]=2D, [4]=3D, [5]=4D.
- lift_out  in  2  motor command from the lift controller: UP=00, DOWN=01, STAY=10.
- req  out  3  call code to the lift controller, registered.
- lamp  out  6  pending-call lamps, same bit mapping as btn.
- busy  out  1  high in ISSUE, WAIT and DWELL.
- fault  out  1  sticky; high when a timeout has occurred.

## Operation
- Call codes:
  - NONE=000, 1U=001, 2U=010, 3U=011, 2D=110, 3D=111, 4D=100.
  - req is NONE in every state except ISSUE.
- Pending register `pend[5:0]`, which drives lamp directly:
  - A rising edge of btn[i] (compared against the previous sampled value) sets pend[i].
  - A held button produces one edge only.
  - A new edge on a bit that is already pending has no effect.
- Arbiter: round-robin over pend.
  - Search starts at the bit after the last granted bit.
  - The pointer resets to bit 0, so 1U has the highest priority after reset.
  - The pointer advances only on an issue.
- FSM states:
  - IDLE: if pend is non-zero and lift_out==STAY, latch the grant index and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle): drive req with the code of the granted bit and clear that pend bit.
    - If a btn edge on the same bit arrives in this cycle, the clear wins and the press is absorbed.
    - Always go to WAIT.
  - WAIT: req=NONE; the counter increments every cycle.
    - If lift_out==STAY, and at least 1 WAIT cycle has elapsed: go to DWELL, or to IDLE if DWELL_CYCLES==0.
    - Else if the counter reaches TIMEOUT_CYCLES: go to FAULT.
  - DWELL: count DWELL_CYCLES cycles, then go to IDLE. lift_out is ignored.
  - FAULT: req=NONE, fault=1, busy=0. Presses still set pend and lamp, but nothing is issued. The only exit is reset.
- One shared counter serves WAIT and DWELL.
  - It clears on every state entry.
  - Width is $clog2(max(DWELL_CYCLES,TIMEOUT_CYCLES)+1).
  - It saturates; it never wraps.
- Simultaneous presses are all latched in the same cycle and served one per issue, in round-robin order.

## Timing
- Reset values:
  - Outputs: req=000, lamp=0, busy=0, fault=0.
  - Internal: state=IDLE, pointer=0, counter=0, btn-history=0.
- Reset mid-operation:
  - Asserting rst_n low forces all registers, and therefore all outputs, to their reset values immediately, with no clock needed.
  - Pending calls are lost.
- Latency without the sync option:
  - btn edge sampled at clock edge t: lamp high from t+1; req valid for cycle t+2 (IDLE, lift_out==STAY).
  - The lamp bit drops at the edge that ends ISSUE.
- Issue spacing: the minimum from one ISSUE to the next is 1 + 1 + DWELL_CYCLES + 1 cycles (ISSUE, WAIT, DWELL, IDLE).
- fault rises on the edge at which the WAIT counter reaches TIMEOUT_CYCLES.

## Configuration
- LIFT_CALL_SYNC_EN:
  - Defined: btn passes through a 2-flop synchronizer before edge detection. All btn-to-output latencies grow by 2 cycles (lamp at t+3, req at t+4).
  - Undefined: btn is taken as synchronous to clk and sampled directly.

## Structure
- Shared package lift_pkg holds:
  - call code constants (CALL_NONE … CALL_4D);
  - motor constants UP, DOWN, STAY;
  - the encoder state enum (IDLE, ISSUE, WAIT, DWELL, FAULT);
  - the button-index-to-code mapping function.
- Sub-module lift_call_rr_arb: 6-bit round-robin arbiter.
  - Inputs: request vector, advance strobe.
  - Outputs: grant index, grant valid.
  - Holds the pointer register internally.

## Test plan
- Reset: with rst_n low mid-WAIT, req=000, lamp=0, busy=0 and fault=0 without a clock edge. After release the block sits in IDLE.
- Single call (DWELL_CYCLES=4, lift_out=STAY): pulse btn[0] at cycle 0.
  - lamp[0]=1 at cycle 1; req=001 for cycle 2 only; lamp[0]=0 at cycle 3.
  - Drive lift_out=UP for cycles 3–4, then STAY: busy=0 after 4 dwell cycles.
- Round robin: press btn[0], btn[3] and btn[5] in the same cycle. Issues are 001, 110, 100 in that order; then press btn[0] again and 001 is issued.
- Held button: hold btn[1] high for 50 cycles. Exactly one req=010 is issued, and lamp[1] clears after it.
- Timeout (TIMEOUT_CYCLES=16): after an issue, hold lift_out=UP. fault=1 after the 16th WAIT cycle.
  - New press on btn[2]: lamp[2]=1 but req stays 000 until reset.
- Sync option (LIFT_CALL_SYNC_EN defined): repeat the single-call scenario. lamp[0] at cycle 3, req=001 at cycle 4.
